// File: rtl/btn_event_ctrl_pkg.sv
// Shared state encodings and default timing for the button event controller.
// Default timing values assume a 100 MHz clock.
package btn_event_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // 0.5 s to long-press, 0.1 s between repeats
    localparam int DEF_CNT_W         = 26;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

endpackage

// File: rtl/btn_event_ctrl_edge_detect.sv
// Registers the previous button level and flags rising/falling edges.
// RST_VAL=1 suppresses a spurious rise for a button held through reset.
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= RST_VAL;
        else     prev <= d;
    end

    assign rise = d & ~prev;
    assign fall = ~d & prev;

endmodule

// File: rtl/btn_event_ctrl.sv
// Converts a debounced button level into press/release/long/repeat pulses,
// a hold level and a press-toggled latch. All outputs are registered.
module btn_event_ctrl
    import btn_event_ctrl_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_db,
    input  logic toggle_clr,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held,
    output logic toggle_q
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;

    edge_detect #(.RST_VAL(1'b1)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (btn_db),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            toggle_q      <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (toggle_clr) toggle_q <= 1'b0;

            // In PRESS/HOLD the previous level is always 1, so a fall is
            // exactly "btn_db low"; checking it first gives release priority.
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state       <= ST_PRESS;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        if (!toggle_clr) toggle_q <= ~toggle_q;
                    end
                end
                ST_PRESS: begin
                    if (fall) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        cnt           <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= ST_HOLD;
                        long_pulse <= 1'b1;
                        held       <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (fall) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        cnt           <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl with LONG_CYCLES=8, REPEAT_CYCLES=4.
// A hold-time reference model pushes expected outputs; they are popped after each edge.
module tb_btn_event_ctrl;

    localparam int L = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_db = 1'b0;
    logic toggle_clr = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held, toggle_q;

    btn_event_ctrl #(.CNT_W(4), .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_db        (btn_db),
        .toggle_clr    (toggle_clr),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .toggle_q      (toggle_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    string phase = "init";
    logic [5:0] exp_q[$];

    // model state: pressed flag, cycles held since press edge, latch, previous level
    logic m_pr = 1'b0;
    int   m_t  = 0;
    logic m_tog = 1'b0;
    logic m_held = 1'b0;
    logic m_prev = 1'b1;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got {prs,rel,lng,rep,hld,tog}=%b expected %b",
                     tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic b, input logic c, input logic r);
        logic p, rl, lp, rp, rise;
        logic [5:0] got;
        logic [5:0] exp;
        @(negedge clk);
        btn_db = b; toggle_clr = c; rst = r;
        p = 1'b0; rl = 1'b0; lp = 1'b0; rp = 1'b0;
        if (r) begin
            m_pr = 1'b0; m_tog = 1'b0; m_held = 1'b0; m_prev = 1'b1; m_t = 0;
        end else begin
            rise = b & ~m_prev;
            if (!m_pr) begin
                if (rise) begin
                    p = 1'b1; m_pr = 1'b1; m_t = 0; m_tog = ~m_tog;
                end
            end else if (!b) begin
                rl = 1'b1; m_pr = 1'b0; m_held = 1'b0;
            end else begin
                m_t++;
                if (m_t == L) lp = 1'b1;
                else if (m_t > L && ((m_t - L) % R) == 0) rp = 1'b1;
                m_held = (m_t >= L);
            end
            if (c) m_tog = 1'b0;
            m_prev = b;
        end
        exp_q.push_back({p, rl, lp, rp, m_held, m_tog});
        @(posedge clk);
        #1;
        got = {press_pulse, release_pulse, long_pulse, repeat_pulse, held, toggle_q};
        exp = exp_q.pop_front();
        chk(phase, got, exp);
    endtask

    task automatic run(input logic b, input logic c, input logic r, input int n);
        for (int i = 0; i < n; i++) step(b, c, r);
    endtask

    initial begin
        phase = "reset";        run(0, 0, 1, 3); run(0, 0, 0, 4);
        phase = "short_press";  run(1, 0, 0, 3); run(0, 0, 0, 4);
        phase = "long_hold";    run(1, 0, 0, 20); run(0, 0, 0, 4);
        // fall on the edge where the long terminal count would hit
        phase = "rel_at_long";  run(1, 0, 0, L); run(0, 0, 0, 4);
        // fall on the edge where a repeat terminal count would hit
        phase = "rel_at_rep";   run(1, 0, 0, L + R); run(0, 0, 0, 4);
        phase = "toggle_seq";
        for (int k = 0; k < 3; k++) begin
            run(1, 0, 0, 2); run(0, 0, 0, 2);
        end
        phase = "clr_w_press";  step(1, 1, 0); run(1, 0, 0, 1); run(0, 0, 0, 2);
        phase = "press_again";  run(1, 0, 0, 2); run(0, 0, 0, 2);
        phase = "clr_idle";     run(0, 1, 0, 1); run(0, 0, 0, 2);
        phase = "held_thru_rst"; run(1, 0, 1, 2); run(1, 0, 0, 4); run(0, 0, 0, 2);
        phase = "repress";      run(1, 0, 0, 3); run(0, 0, 0, 2);
        phase = "rst_mid_hold"; run(1, 0, 0, L + 3); run(1, 0, 1, 1);
        run(1, 0, 0, 3); run(0, 0, 0, 3);
        phase = "after";        run(1, 0, 0, 2); run(0, 0, 0, 3);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover count=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
